video_control_sequencer: RTL

//  Sole master of the video formatter control bus (control_op/control_data). Arbitrates
//  CPU register writes against a bulk palette/sprite loader and serialises each into

---
 rtl/video_control_sequencer_if.sv | 29 ++
 rtl/video_control_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/video_control_sequencer_if.sv
// Request and formatter-control bus of the video control sequencer.
// The sequencer uses the slave view; the requesters and formatter side use master.
interface video_control_sequencer_if;
    logic        cpu_valid;
    logic        cpu_ready;
    logic [7:0]  cpu_op;
    logic [31:0] cpu_data;
    logic        blk_valid;
    logic        blk_ready;
    logic        blk_sprite;
    logic [11:0] blk_index;
    logic [23:0] blk_rgb;
    logic [7:0]  control_op;
    logic [31:0] control_data;

    modport master (
        output cpu_valid, cpu_op, cpu_data,
        output blk_valid, blk_sprite, blk_index, blk_rgb,
        input  cpu_ready, blk_ready,
        input  control_op, control_data
    );

    modport slave (
        input  cpu_valid, cpu_op, cpu_data,
        input  blk_valid, blk_sprite, blk_index, blk_rgb,
        output cpu_ready, blk_ready,
        output control_op, control_data
    );
endinterface

// File: rtl/video_control_sequencer.sv
// Sole master of the video formatter control bus: arbitrates CPU ops against bulk
// palette/sprite loads, serialises them as held ops with idle gaps, defers mode ops to vblank.
module video_control_sequencer #(
    parameter int unsigned HOLD_CYCLES    = 2,
    parameter int unsigned GAP_CYCLES     = 1,
    parameter int unsigned DEFER_MODE_OPS = 1,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                        m_axis_vid_aclk,
    input  logic                        reset,
    input  logic                        vblank_async,
    video_control_sequencer_if.slave    bus,
    output logic                        busy,
    output logic                        deferred
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [7:0]  OP_PALETTE   = 8'd3;
    localparam logic [7:0]  OP_SPR_ADDR  = 8'd14;
    localparam logic [7:0]  OP_SPR_DATA  = 8'd15;

    typedef enum logic [1:0] {IDLE, WAIT_VBL, DRIVE, GAP} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               phase, phase_n;
    logic               rr_blk, rr_blk_n;
    logic [7:0]         op_n, pend_op, pend_op_n;
    logic [31:0]        data_n, pend_data, pend_data_n;
    logic [SYNC_STAGES-1:0] vbl_sync;
    logic               vbl_prev;
    logic               vbl_rise;
    logic               cpu_grant;
    logic               blk_grant;

    function automatic logic is_mode_op(input logic [7:0] op);
        case (op)
            8'd1, 8'd2, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11: is_mode_op = 1'b1;
            default:                                          is_mode_op = 1'b0;
        endcase
    endfunction

    // vblank crosses from the dvi clock; only a 0->1 edge of the synced level releases WAIT_VBL
    always_ff @(posedge m_axis_vid_aclk) begin
        if (reset) begin
            vbl_sync <= '0;
            vbl_prev <= 1'b0;
        end else begin
            vbl_sync <= {vbl_sync[SYNC_STAGES-2:0], vblank_async};
            vbl_prev <= vbl_sync[SYNC_STAGES-1];
        end
    end

    assign vbl_rise = vbl_sync[SYNC_STAGES-1] & ~vbl_prev;

    // Round-robin only matters when both requesters are valid in the same IDLE cycle
    assign cpu_grant     = (state == IDLE) & ~reset & bus.cpu_valid & (~rr_blk | ~bus.blk_valid);
    assign blk_grant     = (state == IDLE) & ~reset & bus.blk_valid & ~cpu_grant;
    assign bus.cpu_ready = cpu_grant;
    assign bus.blk_ready = blk_grant;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        phase_n     = phase;
        rr_blk_n    = rr_blk;
        op_n        = bus.control_op;
        data_n      = bus.control_data;
        pend_op_n   = pend_op;
        pend_data_n = pend_data;
        case (state)
            IDLE: begin
                if (cpu_grant) begin
                    rr_blk_n = 1'b1;
                    if (bus.cpu_op != 8'd0) begin
                        if (DEFER_MODE_OPS != 32'd0 && is_mode_op(bus.cpu_op)) begin
                            state_n     = WAIT_VBL;
                            pend_op_n   = bus.cpu_op;
                            pend_data_n = bus.cpu_data;
                        end else begin
                            state_n = DRIVE;
                            cnt_n   = '0;
                            op_n    = bus.cpu_op;
                            data_n  = bus.cpu_data;
                        end
                    end
                end else if (blk_grant) begin
                    rr_blk_n = 1'b0;
                    state_n  = DRIVE;
                    cnt_n    = '0;
                    if (bus.blk_sprite) begin
                        // Sprite pixel is an ADDR op followed by a DATA op held in pend_*
                        op_n        = OP_SPR_ADDR;
                        data_n      = {20'd0, bus.blk_index};
                        phase_n     = 1'b1;
                        pend_op_n   = OP_SPR_DATA;
                        pend_data_n = {8'd0, bus.blk_rgb};
                    end else begin
                        op_n   = OP_PALETTE;
                        data_n = {bus.blk_index[7:0], bus.blk_rgb};
                    end
                end
            end
            WAIT_VBL: begin
                if (vbl_rise) begin
                    state_n = DRIVE;
                    cnt_n   = '0;
                    op_n    = pend_op;
                    data_n  = pend_data;
                end
            end
            DRIVE: begin
                if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_n = GAP;
                    cnt_n   = '0;
                    op_n    = 8'd0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_n = '0;
                    if (phase) begin
                        state_n = DRIVE;
                        phase_n = 1'b0;
                        op_n    = pend_op;
                        data_n  = pend_data;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge m_axis_vid_aclk) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            phase            <= 1'b0;
            rr_blk           <= 1'b0;
            pend_op          <= '0;
            pend_data        <= '0;
            bus.control_op   <= '0;
            bus.control_data <= '0;
            busy             <= 1'b0;
            deferred         <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            phase            <= phase_n;
            rr_blk           <= rr_blk_n;
            pend_op          <= pend_op_n;
            pend_data        <= pend_data_n;
            bus.control_op   <= op_n;
            bus.control_data <= data_n;
            busy             <= (state_n != IDLE);
            deferred         <= (state_n == WAIT_VBL);
        end
    end

endmodule
